// File: rtl/cpu_run_ctrl_pkg.sv
// Shared state encodings and mode codes for the CPU run controller.
package cpu_run_ctrl_pkg;

  // Panel states first, then the run family (all of which report mode 11).
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLoad     = 3'd1,
    StCheck    = 3'd2,
    StRunRst   = 3'd3,
    StRun      = 3'd4,
    StStepWait = 3'd5,
    StStepExec = 3'd6,
    StHalted   = 3'd7
  } state_e;

  localparam logic [1:0] ModeIdle  = 2'b00;
  localparam logic [1:0] ModeLoad  = 2'b01;
  localparam logic [1:0] ModeCheck = 2'b10;
  localparam logic [1:0] ModeRun   = 2'b11;

  // Panel state matching a non-run mode code.
  function automatic state_e panel_state(input logic [1:0] mode);
    case (mode)
      ModeLoad:  return StLoad;
      ModeCheck: return StCheck;
      default:   return StIdle;
    endcase
  endfunction

  // Mode code reported on cpustate for a given state.
  function automatic logic [1:0] state_code(input state_e st);
    case (st)
      StIdle:  return ModeIdle;
      StLoad:  return ModeLoad;
      StCheck: return ModeCheck;
      default: return ModeRun;
    endcase
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_debounce.sv
// Two-flop synchronizer followed by a stability-count debouncer with a
// registered rising-edge pulse that coincides with the first cycle of db_o=1.
module cpu_run_ctrl_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o
);

  localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            db_q, db_d;
  logic            rise_q, rise_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the current debounced value.
  always_comb begin
    db_d   = db_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      db_d   = sync2_q;
      cnt_d  = '0;
      rise_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchronizer, counter and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-mode sequencer: debounced mode selection, single-step, breakpoint/halt
// stop, CPU enable/reset pulse, RAM ownership and retired-instruction count.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned AW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          SW1,
  input  logic          SW2,
  input  logic          step_mode,
  input  logic          A1,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  input  logic [AW-1:0] pc,
  input  logic          instr_done,
  input  logic          halt_in,
  output logic [1:0]    cpustate,
  output logic          cpu_en,
  output logic          cpu_rst,
  output logic          mem_owner,
  output logic          halted,
  output logic [15:0]   instr_count
);

  logic sw1_db, sw2_db, a1_db;
  logic sw1_rise, sw2_rise, a1_rise;
  logic unused_sig;

  cpu_run_ctrl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sw1 (
    .clk_i (clk), .rst_i (rst), .raw_i (SW1), .db_o (sw1_db), .rise_o (sw1_rise)
  );
  cpu_run_ctrl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sw2 (
    .clk_i (clk), .rst_i (rst), .raw_i (SW2), .db_o (sw2_db), .rise_o (sw2_rise)
  );
  cpu_run_ctrl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_a1 (
    .clk_i (clk), .rst_i (rst), .raw_i (A1), .db_o (a1_db), .rise_o (a1_rise)
  );

  // Mode switches are used as levels, the step button only as an edge.
  assign unused_sig = ^{sw1_rise, sw2_rise, a1_db};

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  mode;
  logic        run_mode, stop_hit, clear_cnt;

  assign mode     = {sw2_db, sw1_db};
  assign run_mode = (mode == ModeRun);
  assign stop_hit = halt_in | (bp_en & (pc == bp_addr));

  // Next-state: leaving mode 11 always wins over any instruction event.
  always_comb begin
    state_d   = state_q;
    clear_cnt = 1'b0;
    case (state_q)
      StIdle, StLoad, StCheck: begin
        if (run_mode) begin
          state_d   = StRunRst;
          clear_cnt = 1'b1;
        end else begin
          state_d = panel_state(mode);
        end
      end
      StRunRst: begin
        if (!run_mode)      state_d = panel_state(mode);
        else if (step_mode) state_d = StStepWait;
        else                state_d = StRun;
      end
      StRun: begin
        if (!run_mode) begin
          state_d = panel_state(mode);
        end else if (instr_done) begin
          if (stop_hit)       state_d = StHalted;
          else if (step_mode) state_d = StStepWait;
        end
      end
      StStepWait: begin
        if (!run_mode)       state_d = panel_state(mode);
        else if (!step_mode) state_d = StRun;
        else if (a1_rise)    state_d = StStepExec;
      end
      StStepExec: begin
        if (!run_mode)       state_d = panel_state(mode);
        else if (instr_done) state_d = stop_hit ? StHalted : StStepWait;
      end
      StHalted: begin
        if (!run_mode) state_d = panel_state(mode);
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    cpustate  = state_code(state_q);
    cpu_en    = (state_q == StRun) || (state_q == StStepExec);
    mem_owner = cpu_en;
    cpu_rst   = (state_q == StRunRst);
    halted    = (state_q == StHalted);
  end

  // Retired-instruction counter, saturating, cleared on run entry.
  always_comb begin
    count_d = count_q;
    if (clear_cnt) begin
      count_d = '0;
    end else if (instr_done && cpu_en && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios with literal
// expectations plus randomized stimulus against a cycle-level model.
module tb_cpu_run_ctrl;

  localparam int DBC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SW1 = 1'b0, SW2 = 1'b0, step_mode = 1'b0, A1 = 1'b0;
  logic        bp_en = 1'b0, instr_done = 1'b0, halt_in = 1'b0;
  logic [15:0] bp_addr = '0, pc = '0;
  logic [1:0]  cpustate;
  logic        cpu_en, cpu_rst, mem_owner, halted;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_errors = 0;

  cpu_run_ctrl #(.DB_CYCLES(DBC), .AW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .SW1         (SW1),
    .SW2         (SW2),
    .step_mode   (step_mode),
    .A1          (A1),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .instr_done  (instr_done),
    .halt_in     (halt_in),
    .cpustate    (cpustate),
    .cpu_en      (cpu_en),
    .cpu_rst     (cpu_rst),
    .mem_owner   (mem_owner),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases: panel (cpustate = selected mode), reset pulse, free run,
  // waiting for a step, executing a step, halted.
  localparam int PPanel = 0, PRst = 1, PRun = 2, PWait = 3, PExec = 4, PHalt = 5;

  int          ph = PPanel;
  logic [1:0]  m_panel = 2'b00;
  logic [15:0] m_cnt = '0;
  logic [15:0] hist [3];
  logic        mdb [3];
  logic        m_rise = 1'b0;
  bit          started = 1'b0;

  always @(posedge clk) begin : model
    logic [1:0]     md;
    logic           run, en, stop, r;
    logic [DBC-1:0] win;
    started = 1'b1;
    if (rst) begin
      ph = PPanel; m_panel = 2'b00; m_cnt = '0; m_rise = 1'b0;
      for (int i = 0; i < 3; i++) begin hist[i] = '0; mdb[i] = 1'b0; end
    end else begin
      md   = {mdb[1], mdb[0]};
      run  = (md == 2'b11);
      en   = (ph == PRun) || (ph == PExec);
      stop = halt_in || (bp_en && (pc == bp_addr));
      if (instr_done && en && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
      if (ph != PPanel && !run) begin
        ph = PPanel; m_panel = md;
      end else begin
        case (ph)
          PPanel: if (run) begin ph = PRst; m_cnt = '0; end else m_panel = md;
          PRst:   ph = step_mode ? PWait : PRun;
          PRun:   if (instr_done) begin
                    if (stop) ph = PHalt;
                    else if (step_mode) ph = PWait;
                  end
          PWait:  if (!step_mode) ph = PRun; else if (m_rise) ph = PExec;
          PExec:  if (instr_done) ph = stop ? PHalt : PWait;
          default: ;
        endcase
      end
      // Debounced value flips once the last DBC synchronized samples all disagree.
      m_rise = 1'b0;
      for (int i = 0; i < 3; i++) begin
        r = (i == 0) ? SW1 : (i == 1) ? SW2 : A1;
        hist[i] = {hist[i][14:0], r};
        win = hist[i][DBC+1:2];
        if (win == {DBC{~mdb[i]}}) begin
          mdb[i] = ~mdb[i];
          if (i == 2 && mdb[i]) m_rise = 1'b1;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("cpustate", {14'b0, cpustate}, {14'b0, ((ph == PPanel) ? m_panel : 2'b11)});
      chk("cpu_en", {15'b0, cpu_en}, {15'b0, ((ph == PRun) || (ph == PExec))});
      chk("mem_owner", {15'b0, mem_owner}, {15'b0, ((ph == PRun) || (ph == PExec))});
      chk("cpu_rst", {15'b0, cpu_rst}, {15'b0, (ph == PRst)});
      chk("halted", {15'b0, halted}, {15'b0, (ph == PHalt)});
      chk("instr_count", instr_count, m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic done_pulse(input logic h, input logic [15:0] p);
    instr_done = 1'b1; halt_in = h; pc = p;
    tick(1);
    instr_done = 1'b0; halt_in = 1'b0;
  endtask

  initial begin
    // Reset
    tick(3);
    rst = 1'b0;
    chk("lit_reset_state", {14'b0, cpustate}, 16'd0);
    chk("lit_reset_count", instr_count, 16'd0);
    chk("lit_reset_en", {15'b0, cpu_en}, 16'd0);

    // Mode 01 appears exactly DBC+3 edges after the raw change
    SW1 = 1'b1;
    tick(DBC + 2);
    chk("lit_load_early", {14'b0, cpustate}, 16'd0);
    tick(1);
    chk("lit_load", {14'b0, cpustate}, 16'd1);
    tick(10);
    SW1 = 1'b0;
    tick(DBC + 4);

    // Short glitch is filtered
    SW1 = 1'b1; tick(2); SW1 = 1'b0;
    tick(DBC + 4);
    chk("lit_glitch", {14'b0, cpustate}, 16'd0);

    // Free run: reset pulse, 5 instructions, then HALT
    SW1 = 1'b1; tick(DBC + 4);
    SW2 = 1'b1;
    tick(DBC + 3);
    chk("lit_entry_rst", {15'b0, cpu_rst}, 16'd1);
    chk("lit_entry_en", {15'b0, cpu_en}, 16'd0);
    tick(1);
    chk("lit_run_en", {15'b0, cpu_en}, 16'd1);
    chk("lit_run_rst", {15'b0, cpu_rst}, 16'd0);
    for (int k = 0; k < 5; k++) begin done_pulse(1'b0, 16'(k)); tick(2); end
    chk("lit_count5", instr_count, 16'd5);
    done_pulse(1'b1, 16'd0);
    chk("lit_halted", {15'b0, halted}, 16'd1);
    chk("lit_halt_en", {15'b0, cpu_en}, 16'd0);
    chk("lit_count6", instr_count, 16'd6);

    // Single-step: three presses, one extra press during execution ignored
    SW1 = 1'b0; tick(DBC + 4);
    chk("lit_check", {14'b0, cpustate}, 16'd2);
    step_mode = 1'b1;
    SW1 = 1'b1; tick(DBC + 4);
    chk("lit_step_wait_en", {15'b0, cpu_en}, 16'd0);
    chk("lit_step_clear", instr_count, 16'd0);
    for (int p = 0; p < 3; p++) begin
      A1 = 1'b1; tick(DBC + 4);
      chk("lit_step_exec", {15'b0, cpu_en}, 16'd1);
      if (p == 0) begin
        A1 = 1'b0; tick(DBC + 4);
        A1 = 1'b1; tick(DBC + 4);
        chk("lit_extra_press", {15'b0, cpu_en}, 16'd1);
      end
      done_pulse(1'b0, 16'(p));
      chk("lit_step_done", {15'b0, cpu_en}, 16'd0);
      A1 = 1'b0; tick(DBC + 4);
    end
    chk("lit_step_count", instr_count, 16'd3);

    // Breakpoint at PC 7
    SW1 = 1'b0; tick(DBC + 4);
    step_mode = 1'b0; bp_en = 1'b1; bp_addr = 16'h0007;
    SW1 = 1'b1; tick(DBC + 5);
    done_pulse(1'b0, 16'd3); tick(2);
    done_pulse(1'b0, 16'd5); tick(2);
    chk("lit_bp_not_yet", {15'b0, halted}, 16'd0);
    done_pulse(1'b0, 16'd7);
    chk("lit_bp_halt", {15'b0, halted}, 16'd1);
    chk("lit_bp_count", instr_count, 16'd3);
    SW1 = 1'b0; tick(DBC + 4);
    chk("lit_bp_check", {14'b0, cpustate}, 16'd2);
    chk("lit_bp_owner", {15'b0, mem_owner}, 16'd0);
    SW1 = 1'b1; tick(DBC + 3);
    chk("lit_rerun_rst", {15'b0, cpu_rst}, 16'd1);
    chk("lit_rerun_clear", instr_count, 16'd0);

    // Reset mid-run with count 9
    bp_en = 1'b0;
    tick(2);
    for (int k = 0; k < 9; k++) begin done_pulse(1'b0, 16'd20); tick(1); end
    chk("lit_count9", instr_count, 16'd9);
    rst = 1'b1; tick(1);
    chk("lit_rst_state", {14'b0, cpustate}, 16'd0);
    chk("lit_rst_en", {15'b0, cpu_en}, 16'd0);
    chk("lit_rst_count", instr_count, 16'd0);
    tick(1);
    rst = 1'b0; SW1 = 1'b0; SW2 = 1'b0;
    tick(DBC + 4);

    // Randomized stimulus
    bp_addr = 16'd9;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        if ($urandom_range(0, 1) == 0) begin SW1 = 1'b1; SW2 = 1'b1; end
        else begin SW1 = 1'($urandom_range(0, 1)); SW2 = 1'($urandom_range(0, 1)); end
      end
      if ($urandom_range(0, 99) == 0) SW1 = ~SW1;
      if ($urandom_range(0, 39) == 0) step_mode = ~step_mode;
      if ($urandom_range(0, 7) == 0) A1 = ~A1;
      if ($urandom_range(0, 49) == 0) bp_en = ~bp_en;
      instr_done = ($urandom_range(0, 3) == 0);
      halt_in    = ($urandom_range(0, 15) == 0);
      pc         = 16'($urandom_range(0, 15));
      rst        = ($urandom_range(0, 699) == 0);
      tick(1);
    end
    rst = 1'b0; instr_done = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Sequencer that owns the 8-bit CPU's operating mode. It replaces the purely combinational switch decode with debounced mode selection, single-step and breakpoint control, a CPU clock-enable/reset, and RAM-port ownership. It sits in the top level between the front-panel switches/button and the `cpu`, `ram` and `light_show` instances, and runs on the `clk_quick` domain.

## Interface
Parameters:
- `DB_CYCLES`, default 4: number of consecutive stable samples before a debounced input changes. Use 4 for simulation and 20000 for synthesis.
- `AW`, default 16: address/PC width.

Ports:
- `clk`  in  1  single clock (`clk_quick`).
- `rst`  in  1  reset; synchronous, active-high.
- `SW1`, `SW2`  in  1 each  raw mode switches.
- `step_mode`  in  1  level input:
  - 1 = single-step in RUN;
  - 0 = free-run.
- `A1`  in  1  raw step button, active-high.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  AW  breakpoint PC.
- `pc`  in  AW  CPU program counter.
- `instr_done`  in  1  one-cycle pulse from the CPU at each instruction boundary.
- `halt_in`  in  1  CPU executed HALT. Level, sampled with `instr_done`.
- `cpustate`  out  2  mode code, same encoding as the existing one:
  - 00 idle;
  - 01 load;
  - 10 check;
  - 11 run.
- `cpu_en`  out  1  CPU clock enable.
- `cpu_rst`  out  1  one-cycle CPU reset pulse.
- `mem_owner`  out  1  RAM port owner: 0 = panel, 1 = CPU.
- `halted`  out  1  high in HALTED.
- `instr_count`  out  16  instructions retired since the last `cpu_rst`.

## Operation
- Inputs `SW1`, `SW2` and `A1` each pass through a 2-flop synchronizer and then a debouncer.
- The debounced mode is `{sw2_db, sw1_db}`.
- States and their outputs:
  - IDLE: `cpustate`=00.
  - LOAD: 01.
  - CHECK: 10.
  - RUN: 11, `cpu_en`=1.
  - STEP_WAIT: 11, `cpu_en`=0.
  - STEP_EXEC: 11, `cpu_en`=1.
  - HALTED: 11, `cpu_en`=0, `halted`=1.
- `mem_owner`=1 only in RUN and STEP_EXEC.
- Transitions among IDLE, LOAD and CHECK follow the debounced mode directly.
- Entering run mode (mode=11) from IDLE, LOAD or CHECK:
  - `cpu_rst` pulses for 1 cycle;
  - `instr_count` clears;
  - the next state is RUN if `step_mode`=0, else STEP_WAIT.
- In RUN:
  - `step_mode` going to 1 moves to STEP_WAIT at the next `instr_done`. Mid-instruction is never cut.
- In STEP_WAIT:
  - `step_mode`=0 moves to RUN;
  - a debounced `A1` rising edge moves to STEP_EXEC.
- In STEP_EXEC:
  - `instr_done` moves to STEP_WAIT.
  - Further `A1` edges are ignored.
- Stop conditions, in RUN or STEP_EXEC on `instr_done`:
  - `halt_in`=1 → HALTED;
  - else if `bp_en` && `pc`==`bp_addr` → HALTED.
  - Halt takes priority over the step return.
- HALTED is left only when the debounced mode leaves 11. Run cannot restart without passing through a non-run mode.
- Leaving mode 11 from any run-family state goes to the matching panel state immediately: `cpu_en`=0, `mem_owner`=0, no `cpu_rst`.
- `instr_count`:
  - +1 on each `instr_done` while `cpu_en`=1;
  - saturates at 16'hFFFF.

## Timing
- Reset value of every output is 0. The state resets to IDLE, and the debouncers reset to 0.
- Input latency: a raw change that is stable reaches the debounced value DB_CYCLES+2 cycles after it first appears.
- The FSM updates on the next edge, and outputs are registered from the state.
- Entry into run mode at edge N:
  - `cpu_rst`=1 and `cpu_en`=0 during cycle N;
  - in free-run, `cpu_en`=1 from N+1.
- `instr_done` at edge M causing a stop or step completion gives `cpu_en`=0 from cycle M+1.
- Glitches shorter than DB_CYCLES never change state.
- Simultaneous events:
  - mode leaving 11 and `instr_done` in the same cycle: the mode change wins, with no HALTED;
  - `instr_done` arriving with `cpu_en`=0 is ignored.
- `rst` asserted mid-run returns everything to reset values on the next edge.

## Structure
- Shared include `cpu_ctrl_defs.vh` holds:
  - the state encodings;
  - the mode codes 00/01/10/11.
- Sub-module `debounce`, parameterised by DB_CYCLES. It contains the synchronizer, a stability counter and the output register, and has a rising-edge pulse output. It is instantiated three times.

## Test plan
- Reset, then mode=01 held 10 cycles → `cpustate`=01 at cycle DB_CYCLES+3. All other outputs stay 0.
- A 2-cycle glitch on `SW1` in IDLE → `cpustate` stays 00.
- Mode 01→11 with `step_mode`=0 → one `cpu_rst` pulse, then `cpu_en`=1. 5 `instr_done` pulses → `instr_count`=5. A 6th with `halt_in`=1 → `halted`=1, `cpu_en`=0 next cycle.
- `step_mode`=1, run mode, 3 debounced `A1` presses, each followed by `instr_done` → `instr_count`=3. Extra `A1` presses during STEP_EXEC are ignored.
- `bp_en`=1, `bp_addr`=16'h0007, `pc` reaches 7 at `instr_done` → HALTED. Mode→10 → `cpustate`=10, `mem_owner`=0. Mode→11 → fresh `cpu_rst`, count cleared.
- `rst` pulsed while in RUN with count=9 → all outputs 0, state IDLE.
